// File: rtl/i2s_rx_deserializer.sv
// rtl/i2s_rx_deserializer.sv - Philips I2S receiver, oversampled pins to parallel signed L/R samples (optional: I2S_RX_ERR_CNT_EN)
module i2s_rx_deserializer #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2s_bclk,
    input  logic              i2s_lrclk,
    input  logic              i2s_sdata,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    output logic              sample_valid,
    output logic              frame_err
`ifdef I2S_RX_ERR_CNT_EN
    ,
    output logic [15:0]       err_count
`endif
);

    localparam logic [CNT_W-1:0] DATA_W_C = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lr_sync_q;
    logic [SYNC_STAGES-1:0] sd_sync_q;
    logic                   bclk_prev_q;
    logic                   rise_q;
    logic                   lr_smp_q;
    logic                   sd_smp_q;

    state_t                 state_q;
    logic                   lr_prev_q;
    logic [DATA_W-1:0]      shift_q;
    logic [DATA_W-1:0]      shift_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [DATA_W-1:0]      pend_q;
    logic                   pend_vld_q;
    logic [DATA_W-1:0]      left_q;
    logic [DATA_W-1:0]      right_q;
    logic                   valid_q;
    logic                   err_q;

    logic                   boundary;
    logic                   word_good;

    // Identical synchronizer chains keep bclk, lrclk and sdata mutually aligned; rise and samples are then registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            bclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            lr_smp_q    <= 1'b0;
            sd_smp_q    <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
            sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], i2s_sdata};
            bclk_prev_q <= bclk_sync_q[SYNC_STAGES-1];
            rise_q      <= bclk_sync_q[SYNC_STAGES-1] & ~bclk_prev_q;
            lr_smp_q    <= lr_sync_q[SYNC_STAGES-1];
            sd_smp_q    <= sd_sync_q[SYNC_STAGES-1];
        end
    end

    // Shift register and bit counter after absorbing the bit sampled on this bclk rise
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (cnt_q < DATA_W_C) begin
            shift_d = {shift_q[DATA_W-2:0], sd_smp_q};
        end
        if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign boundary  = rise_q && (lr_smp_q != lr_prev_q);
    assign word_good = (cnt_d >= DATA_W_C);

    // Slot FSM: collects bits, closes slots on lrclk boundaries, pairs left with right and emits registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lr_prev_q  <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (rise_q) begin
                lr_prev_q <= lr_smp_q;
                case (state_q)
                    IDLE: begin
                        // Only a right-to-left boundary starts a frame, so a stream joined mid-frame is skipped
                        if (boundary && !lr_smp_q) begin
                            state_q <= LEFT;
                            cnt_q   <= '0;
                            shift_q <= '0;
                        end
                    end
                    LEFT: begin
                        if (!boundary) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_d;
                        end else begin
                            cnt_q   <= '0;
                            shift_q <= '0;
                            if (!lr_smp_q) begin
                                err_q      <= 1'b1;
                                pend_vld_q <= 1'b0;
                                state_q    <= IDLE;
                            end else begin
                                if (word_good) begin
                                    pend_q     <= shift_d;
                                    pend_vld_q <= 1'b1;
                                end else begin
                                    err_q      <= 1'b1;
                                    pend_vld_q <= 1'b0;
                                end
                                state_q <= RIGHT;
                            end
                        end
                    end
                    RIGHT: begin
                        if (!boundary) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_d;
                        end else begin
                            cnt_q      <= '0;
                            shift_q    <= '0;
                            pend_vld_q <= 1'b0;
                            if (lr_smp_q) begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                if (!word_good) begin
                                    err_q <= 1'b1;
                                end else if (pend_vld_q) begin
                                    left_q  <= pend_q;
                                    right_q <= shift_d;
                                    valid_q <= 1'b1;
                                end
                                state_q <= LEFT;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef I2S_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of frame_err pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign left_out     = left_q;
    assign right_out    = right_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb/tb_i2s_rx_deserializer.sv - directed-stream bench with a bit-queue slot model for i2s_rx_deserializer
module tb_i2s_rx_deserializer;

    localparam int DW  = 24;
    localparam int SS  = 2;
    localparam int LAT = SS + 2;

    logic          clk;
    logic          rst;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_sdata;
    logic [DW-1:0] left_out;
    logic [DW-1:0] right_out;
    logic          sample_valid;
    logic          frame_err;
`ifdef I2S_RX_ERR_CNT_EN
    logic [15:0]   err_count;
`endif

    i2s_rx_deserializer #(.DATA_W(DW), .SYNC_STAGES(SS), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .left_out     (left_out),
        .right_out    (right_out),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
`ifdef I2S_RX_ERR_CNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic rst_s = 1'b1;

    // Slot-level model state
    int            m_mode = 0;      // 0 idle, 1 collecting left, 2 collecting right
    logic          m_lrp  = 1'b0;
    int            m_n    = 0;
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] m_pend = '0;
    logic          m_pv   = 1'b0;

    int            ev_due[$];
    logic          ev_kind[$];
    logic [DW-1:0] ev_l[$];
    logic [DW-1:0] ev_r[$];

    logic [DW-1:0] exp_l = '0;
    logic [DW-1:0] exp_r = '0;
    int            exp_ecnt = 0;
    int            nv_seen = 0;
    int            ne_seen = 0;
    int            last_valid_cyc = 0;
    int            lat_b = 0;
    logic          arm_lat = 1'b0;
    logic          prev_sd = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   = cyc + 1;
        rst_s = rst;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input logic kind, input logic [DW-1:0] l, input logic [DW-1:0] r);
        ev_due.push_back(cyc + LAT);
        ev_kind.push_back(kind);
        ev_l.push_back(l);
        ev_r.push_back(r);
    endtask

    // Model of one bclk rise: bits fill the word MSB first; a change of lr closes the slot including this bit
    task automatic model_rise(input logic lr, input logic sd);
        logic good;
        if (m_mode != 0) begin
            if (m_n < DW) m_word[DW-1-m_n] = sd;
            m_n++;
        end
        if (lr != m_lrp) begin
            if (arm_lat && !lr) begin
                lat_b   = cyc;
                arm_lat = 1'b0;
            end
            good = (m_n >= DW);
            if (m_mode == 0) begin
                if (!lr) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!lr) begin
                    push_ev(1'b0, '0, '0);
                    m_mode = 0;
                end else begin
                    m_pv = good;
                    if (good) m_pend = m_word;
                    else push_ev(1'b0, '0, '0);
                    m_mode = 2;
                end
            end else begin
                if (lr) begin
                    push_ev(1'b0, '0, '0);
                    m_mode = 0;
                end else begin
                    if (!good) push_ev(1'b0, '0, '0);
                    else if (m_pv) push_ev(1'b1, m_pend, m_word);
                    m_mode = 1;
                end
                m_pv = 1'b0;
            end
            m_n    = 0;
            m_word = '0;
        end
        m_lrp = lr;
    endtask

    // One bclk period: lr/sd change with bclk low, sampled on the rise 4 clk cycles later
    task automatic period(input logic lr, input logic sd);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_sdata = sd;
        repeat (4) @(posedge clk);
        #1;
        i2s_bclk = 1'b1;
        model_rise(lr, sd);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // A slot of len bclks: data is delayed by one bclk relative to lrclk
    task automatic send_slot(input logic lr, input int len, input logic [DW-1:0] word);
        logic b;
        for (int i = 0; i < len; i++) begin
            b = (i < DW) ? word[DW-1-i] : 1'b0;
            period(lr, prev_sd);
            prev_sd = b;
        end
    endtask

    task automatic do_reset();
        i2s_bclk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst    = 1'b1;
        m_mode = 0;
        m_lrp  = 1'b0;
        m_n    = 0;
        m_word = '0;
        m_pv   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Every-cycle comparison against the model's expected strobes and held outputs
    always @(negedge clk) begin
        logic exp_v;
        logic exp_e;
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (cyc > 0) begin
            if (rst_s) begin
                exp_l    = '0;
                exp_r    = '0;
                exp_ecnt = 0;
                ev_due.delete();
                ev_kind.delete();
                ev_l.delete();
                ev_r.delete();
            end else if (ev_due.size() > 0 && ev_due[0] == cyc) begin
                if (ev_kind[0]) begin
                    exp_v = 1'b1;
                    exp_l = ev_l[0];
                    exp_r = ev_r[0];
                end else begin
                    exp_e = 1'b1;
                end
                void'(ev_due.pop_front());
                void'(ev_kind.pop_front());
                void'(ev_l.pop_front());
                void'(ev_r.pop_front());
            end
            chk("sample_valid", {31'd0, sample_valid}, {31'd0, exp_v});
            chk("frame_err", {31'd0, frame_err}, {31'd0, exp_e});
            chk("left_out", {8'd0, left_out}, {8'd0, exp_l});
            chk("right_out", {8'd0, right_out}, {8'd0, exp_r});
`ifdef I2S_RX_ERR_CNT_EN
            chk("err_count", {16'd0, err_count}, exp_ecnt);
`endif
            if (exp_e && exp_ecnt < 65535) exp_ecnt++;
            if (sample_valid) begin
                nv_seen++;
                last_valid_cyc = cyc;
            end
            if (frame_err) ne_seen++;
        end
    end

    initial begin
        rst       = 1'b1;
        i2s_bclk  = 1'b0;
        i2s_lrclk = 1'b0;
        i2s_sdata = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset left_out", {8'd0, left_out}, 32'h0);
        chk("reset right_out", {8'd0, right_out}, 32'h0);
        chk("reset sample_valid", {31'd0, sample_valid}, 32'h0);
        chk("reset frame_err", {31'd0, frame_err}, 32'h0);

        // Join mid right slot, then two 32-bit-slot frames
        send_slot(1'b1, 10, 24'h000000);
        send_slot(1'b0, 32, 24'h123456);
        send_slot(1'b1, 32, 24'hFEDCBA);
        send_slot(1'b0, 32, 24'h123456);
        send_slot(1'b1, 32, 24'hFEDCBA);

        // 24-bit slots with sign extremes
        send_slot(1'b0, 24, 24'h800000);
        chk("32b left literal", {8'd0, left_out}, 32'h123456);
        chk("32b right literal", {8'd0, right_out}, 32'hFEDCBA);
        chk("32b valid count", nv_seen, 2);
        chk("32b err count", ne_seen, 0);
        arm_lat = 1'b1;
        send_slot(1'b1, 24, 24'h7FFFFF);

        // Truncated left slot, then a good right slot, then a good frame
        send_slot(1'b0, 16, 24'hAAAA55);
        chk("latency", last_valid_cyc - lat_b, LAT);
        chk("24b left literal", {8'd0, left_out}, 32'h800000);
        chk("24b right literal", {8'd0, right_out}, 32'h7FFFFF);
        send_slot(1'b1, 24, 24'h111111);
        chk("trunc err count", ne_seen, 1);
        chk("trunc valid count", nv_seen, 3);
        chk("trunc left held", {8'd0, left_out}, 32'h800000);
        send_slot(1'b0, 24, 24'h0F0F0F);
        send_slot(1'b1, 24, 24'hF0F0F0);

        // Reset in the middle of a left slot, recover on the next right-to-left boundary
        send_slot(1'b0, 10, 24'h5A5A5A);
        chk("recover left literal", {8'd0, left_out}, 32'h0F0F0F);
        chk("recover right literal", {8'd0, right_out}, 32'hF0F0F0);
        do_reset();
        chk("midreset left_out", {8'd0, left_out}, 32'h0);
        chk("midreset right_out", {8'd0, right_out}, 32'h0);
        send_slot(1'b0, 14, 24'h5A5A5A);
        send_slot(1'b1, 24, 24'h000001);
        send_slot(1'b0, 24, 24'h654321);
        send_slot(1'b1, 24, 24'hFFFFFF);
        send_slot(1'b0, 24, 24'h000000);
        repeat (10) @(posedge clk);
        #1;
        chk("final left literal", {8'd0, left_out}, 32'h654321);
        chk("final right literal", {8'd0, right_out}, 32'hFFFFFF);
        chk("final valid count", nv_seen, 5);
        chk("final err count", ne_seen, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
